ys_poly_small_seq: RTL
======================

# ys_poly_small_seq

Sequencer for the `ys_poly_small` mode-3 datapath (`g[i] = 3*(g[i-1]-g[i])`, `g[0] = -3*g[0]`). It sits directly upstream of `ys_poly_small_exe3`. It walks the packed polynomial in RAM1 two words per cycle and drives the RAM1 read addresses. It generates the `f_ctr` first-beat flag aligned to the data arriving at the exe stage, and issues the delayed RAM2 write addresses and enables so results land at the same word positions.

## Interface
- `N_WORDS`, 128: packed `DW_PH` words per polynomial (4 × `DW_13` coeffs each); must be even and ≥ 4.
- `AW`, 7: RAM address width; 2^AW ≥ N_WORDS.
- `RD_LAT`, 1: RAM1 read latency in cycles (1 or 2).
- `EXE_LAT`, 0: exe-stage latency from `ram1_dout*` to `ram2_din*` (0 or 1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to process one polynomial.
- `busy` out 1: high from the cycle after accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse after the last RAM2 write.
- `ram1_en` out 1: RAM1 read enable (both ports).
- `ram1_addra` out AW: RAM1 port A address, even word 2k.
- `ram1_addrb` out AW: RAM1 port B address, odd word 2k+1.
- `f_ctr` out 1: high exactly while exe sees words 0/1.
- `ram2_wea` out 1: RAM2 port A write enable.
- `ram2_web` out 1: RAM2 port B write enable.
- `ram2_addra` out AW: RAM2 port A write address.
- `ram2_addrb` out AW: RAM2 port B write address.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start` → RUN, pair counter k = 0.
  - RUN: issue reads for pair k each cycle; after k = N_WORDS/2−1 → DRAIN.
  - DRAIN: wait until the pipeline valid shift register is empty → DONE.
  - DONE: pulse `done`, then → IDLE.
- Reads: in RUN, `ram1_en`=1, `ram1_addra`=2k, `ram1_addrb`=2k+1; k increments by 1 per cycle, no stalls.
- Pipeline: 1-bit valid plus AW-bit pair index, shifted RD_LAT+EXE_LAT stages. Tap at RD_LAT gives `f_ctr` (valid && index==0). Tap at RD_LAT+EXE_LAT gives `ram2_wea`/`ram2_web`, with `ram2_addra`=2·index and `ram2_addrb`=2·index+1.
- Word order is strictly ascending. The exe stage's carried lane-3 coefficient (word 2k+1 → word 2k+2) relies on this; the sequencer never reorders or repeats a pair.
- `start` while `busy` is ignored; no queuing.
- `start` in the same cycle as `done` is ignored; a new request needs IDLE.
- Padding coefficients beyond NTRU_N inside the last word are passed through; masking is not this block's job.

## Timing
- Reset values: `busy`, `done`, `ram1_en`, `f_ctr`, `ram2_wea`, `ram2_web` = 0; all addresses = 0; FSM = IDLE; valid pipe cleared.
- `start` sampled high at edge 0:
  - First read (addr 0/1) is registered at edge 1.
  - `f_ctr` high in cycle 1+RD_LAT only.
  - First write in cycle 1+RD_LAT+EXE_LAT.
  - Last read in cycle N_WORDS/2.
  - Last write in cycle N_WORDS/2+RD_LAT+EXE_LAT.
  - `done` one cycle after the last write.
- Defaults (N_WORDS=128, RD_LAT=1, EXE_LAT=0): reads cycles 1–64, `f_ctr` cycle 2, writes cycles 2–65, `done` cycle 66. Throughput is 2 words per cycle.
- `rst` mid-operation: in the next cycle all enables, `f_ctr`, `busy` and `done` are 0; in-flight writes are dropped; FSM → IDLE.
- Address outputs hold their last value when enables are low; the bench must check addresses only when the matching enable is high.

## Structure
- `param.v` / `ys_poly_small.vh` hold `DW_PH`, `DW_13`, `NTRU_N`, the derived `N_WORDS`, and the FSM state encodings (2-bit localparams `ST_IDLE`, `ST_RUN`, `ST_DRAIN`, `ST_DONE`).
- One sub-module: `ys_poly_small_vpipe` — parameterised depth-D shift register of {valid, index}, with a reset clear and configurable taps. It is instantiated once; taps are at RD_LAT and RD_LAT+EXE_LAT.
- Top level contains the FSM, pair counter and output registers.

## Test plan
- Reset, then idle 10 cycles → every output 0, `busy`=0.
- `start` at cycle 0 (defaults) → reads 0/1…126/127 in cycles 1–64; `f_ctr` only in cycle 2; writes 0/1…126/127 in cycles 2–65; `done` only in cycle 66; `busy` cycles 1–66.
- End-to-end with exe3 and RAM models: polynomial with coeff i = i mod 8192 → RAM2 matches the golden `3*(g[i-1]-g[i])` and `-3*g[0]` mod 2^13 for all 512 slots.
- `start` re-pulsed at cycles 10 and 66 → single run; `done` exactly once, in cycle 66.
- `rst` asserted at cycle 30 for 1 cycle → cycle 31 all outputs 0, no writes after cycle 30; a fresh `start` at cycle 40 gives the full 64-pair sequence.
- RD_LAT=2, EXE_LAT=1 → `f_ctr` cycle 3, writes cycles 4–67, `done` cycle 68.

Source files
------------

// File: rtl/ys_poly_small_seq_pkg.sv
// Shared constants and FSM encoding for the ys_poly_small mode-3 sequencer.
package ys_poly_small_seq_pkg;

    localparam int DW_13           = 13;
    localparam int DW_PH           = 4 * DW_13;
    localparam int NTRU_N          = 509;
    localparam int COEFFS_PER_WORD = DW_PH / DW_13;
    // Word count rounded up to an even number so words can be walked in pairs.
    localparam int N_WORDS_DEF     = 2 * ((((NTRU_N + COEFFS_PER_WORD - 1) / COEFFS_PER_WORD) + 1) / 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ys_poly_small_seq_vpipe.sv
// Depth-D shift register of {valid, pair index} with two read taps.
// Index stages only load on a valid entry, so tap indices hold their last value.
module ys_poly_small_seq_vpipe #(
    parameter int D     = 1,
    parameter int PW    = 6,
    parameter int TAP_A = 1,
    parameter int TAP_B = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_idx,
    output logic          tap_a_valid,
    output logic [PW-1:0] tap_a_idx,
    output logic          tap_b_valid,
    output logic [PW-1:0] tap_b_idx,
    output logic          drain_ok
);

    logic [D-1:0]  valid_reg;
    logic [PW-1:0] idx_reg [D];

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_stage
            logic          v_in;
            logic [PW-1:0] i_in;
            if (gi == 0) begin : g_first
                assign v_in = in_valid;
                assign i_in = in_idx;
            end else begin : g_rest
                assign v_in = valid_reg[gi-1];
                assign i_in = idx_reg[gi-1];
            end
            // Advance one stage per cycle; reset drops everything in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    idx_reg[gi]   <= '0;
                end else begin
                    valid_reg[gi] <= v_in;
                    if (v_in) begin
                        idx_reg[gi] <= i_in;
                    end
                end
            end
        end

        // The last stage empties on the next edge, so only earlier stages and
        // the input need to be clear for the pipe to be empty next cycle.
        if (D == 1) begin : g_drain1
            assign drain_ok = ~in_valid;
        end else begin : g_drainn
            assign drain_ok = ~in_valid & ~(|valid_reg[D-2:0]);
        end
    endgenerate

    assign tap_a_valid = valid_reg[TAP_A-1];
    assign tap_a_idx   = idx_reg[TAP_A-1];
    assign tap_b_valid = valid_reg[TAP_B-1];
    assign tap_b_idx   = idx_reg[TAP_B-1];

endmodule

// File: rtl/ys_poly_small_seq.sv
// Sequencer for the ys_poly_small mode-3 datapath: walks RAM1 two words per
// cycle in ascending order, flags the first beat at the exe stage and issues
// delayed RAM2 write addresses matching the read word positions.
module ys_poly_small_seq
    import ys_poly_small_seq_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int AW      = 7,
    parameter int RD_LAT  = 1,
    parameter int EXE_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ram1_en,
    output logic [AW-1:0] ram1_addra,
    output logic [AW-1:0] ram1_addrb,
    output logic          f_ctr,
    output logic          ram2_wea,
    output logic          ram2_web,
    output logic [AW-1:0] ram2_addra,
    output logic [AW-1:0] ram2_addrb
);

    localparam int PW = AW - 1;
    localparam int D  = RD_LAT + EXE_LAT;
    localparam logic [PW-1:0] LAST_PAIR = PW'(N_WORDS / 2 - 1);

    state_t        state_reg, state_next;
    logic          ram1_en_reg;
    logic [PW-1:0] pair_reg;
    logic [AW-1:0] ram1_addra_reg, ram1_addrb_reg;
    logic          wr_seen_reg;
    logic          fc_valid, wr_valid, drain_ok;
    logic [PW-1:0] fc_idx, wr_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start outside IDLE (including the DONE cycle) is dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (pair_reg == LAST_PAIR) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_ok) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Read issue: pair 0 is registered on the accepting edge, then one pair per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram1_en_reg    <= 1'b0;
            pair_reg       <= '0;
            ram1_addra_reg <= '0;
            ram1_addrb_reg <= '0;
        end else begin
            ram1_en_reg <= 1'b0;
            if (state_reg == ST_IDLE && start) begin
                ram1_en_reg    <= 1'b1;
                pair_reg       <= '0;
                ram1_addra_reg <= '0;
                ram1_addrb_reg <= AW'(1);
            end else if (state_reg == ST_RUN && pair_reg != LAST_PAIR) begin
                ram1_en_reg    <= 1'b1;
                pair_reg       <= pair_reg + 1'b1;
                ram1_addra_reg <= {pair_reg + 1'b1, 1'b0};
                ram1_addrb_reg <= {pair_reg + 1'b1, 1'b1};
            end
        end
    end

    // Keeps ram2_addrb at 0 out of reset, then tracks the held write index.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_seen_reg <= 1'b0;
        end else if (wr_valid) begin
            wr_seen_reg <= 1'b1;
        end
    end

    ys_poly_small_seq_vpipe #(
        .D     (D),
        .PW    (PW),
        .TAP_A (RD_LAT),
        .TAP_B (D)
    ) u_vpipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (ram1_en_reg),
        .in_idx      (pair_reg),
        .tap_a_valid (fc_valid),
        .tap_a_idx   (fc_idx),
        .tap_b_valid (wr_valid),
        .tap_b_idx   (wr_idx),
        .drain_ok    (drain_ok)
    );

    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign ram1_en    = ram1_en_reg;
    assign ram1_addra = ram1_addra_reg;
    assign ram1_addrb = ram1_addrb_reg;
    assign f_ctr      = fc_valid && (fc_idx == '0);
    assign ram2_wea   = wr_valid;
    assign ram2_web   = wr_valid;
    assign ram2_addra = {wr_idx, 1'b0};
    assign ram2_addrb = {wr_idx, wr_seen_reg | wr_valid};

endmodule
